// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding and counter parameters for hazard_ctrl
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at CNT_MAX instead of wrapping
module sat_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = sat_inc(count_q, inc);
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for load-use, taken branches and slow data memory
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IFID_RS1,
  input  logic [4:0]  IFID_RS2,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_RD,
  input  logic        EX_BranchTaken,
  input  logic        EXMEM_MemAccess,
  input  logic        DMem_Ready,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic [1:0]  State,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushEvents
);
  state_e state_q, state_d;
  logic load_use, mem_wait, lu_ok, br_ev, lu_ev;
  assign load_use = IDEX_MemRead & (IDEX_RD != 5'd0) & (IDEX_RD == IFID_RS1 | IDEX_RD == IFID_RS2);
  assign mem_wait = EXMEM_MemAccess & ~DMem_Ready;
  // ID holds a bubble in FLUSH and the stalled load already advanced in LOAD_STALL
  assign lu_ok = (state_q == RUN) | (state_q == MEM_WAIT);
  assign br_ev = ~reset & ~mem_wait & EX_BranchTaken;
  assign lu_ev = ~reset & ~mem_wait & ~EX_BranchTaken & load_use & lu_ok;
  always_comb begin
    PCWrite     = ~reset & ~mem_wait & ~lu_ev;
    IFID_Write  = ~reset & ~mem_wait & ~lu_ev;
    IDEX_Write  = ~reset & ~mem_wait;
    EXMEM_Write = ~reset & ~mem_wait;
    IFID_Flush  = reset | br_ev;
    IDEX_Flush  = reset | br_ev | lu_ev;
    state_d     = mem_wait ? MEM_WAIT : br_ev ? FLUSH : lu_ev ? LOAD_STALL : RUN;
  end
  always_ff @(posedge clk) state_q <= reset ? RUN : state_d;
  assign State = state_q;
  sat_counter u_stall_cnt (.clk(clk), .reset(reset), .inc(lu_ev), .count(StallCycles));
  sat_counter u_flush_cnt (.clk(clk), .reset(reset), .inc(br_ev), .count(FlushEvents));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors checked every cycle against a spec-level model
module tb_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] IFID_RS1 = 0, IFID_RS2 = 0, IDEX_RD = 0;
  logic IDEX_MemRead = 0, EX_BranchTaken = 0, EXMEM_MemAccess = 0, DMem_Ready = 0;
  logic PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Flush;
  logic [1:0] State;
  logic [15:0] StallCycles, FlushEvents;
  int n_checks = 0, n_fail = 0;
  int m_state = 0, m_stall = 0, m_flush = 0;
  bit valid = 0;
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD), .EX_BranchTaken(EX_BranchTaken),
    .EXMEM_MemAccess(EXMEM_MemAccess), .DMem_Ready(DMem_Ready), .PCWrite(PCWrite),
    .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write), .EXMEM_Write(EXMEM_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .State(State),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_lu();
    return IDEX_MemRead && IDEX_RD != 0 && (IDEX_RD == IFID_RS1 || IDEX_RD == IFID_RS2);
  endfunction
  function automatic int m_event();
    if (reset) return 0;
    if (EXMEM_MemAccess && !DMem_Ready) return 3;
    if (EX_BranchTaken) return 2;
    if (m_lu() && (m_state == 0 || m_state == 3)) return 1;
    return 0;
  endfunction
  always @(posedge clk) begin
    int ev;
    ev = m_event();
    valid <= 1;
    m_state = ev;
    if (reset) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (ev == 1) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (ev == 2) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
    end
  end
  always @(negedge clk) if (valid) begin
    int ev;
    int wr, st;
    ev = m_event();
    wr = reset ? 0 : (ev == 3) ? 0 : 1;
    st = (ev == 1) ? 0 : wr;
    check("m_State", State, m_state);
    check("m_StallCycles", StallCycles, m_stall);
    check("m_FlushEvents", FlushEvents, m_flush);
    check("m_PCWrite", PCWrite, st);
    check("m_IFID_Write", IFID_Write, st);
    check("m_IDEX_Write", IDEX_Write, wr);
    check("m_EXMEM_Write", EXMEM_Write, wr);
    check("m_IFID_Flush", IFID_Flush, (reset || ev == 2) ? 1 : 0);
    check("m_IDEX_Flush", IDEX_Flush, (reset || ev == 2 || ev == 1) ? 1 : 0);
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    IDEX_MemRead = 0; IDEX_RD = 0; IFID_RS1 = 0; IFID_RS2 = 0;
    EX_BranchTaken = 0; EXMEM_MemAccess = 0; DMem_Ready = 0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1;
    next();
    reset = 0;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_State", State, 0);
    check("rst_PCWrite", PCWrite, 0);
    check("rst_EXMEM_Write", EXMEM_Write, 0);
    check("rst_IFID_Flush", IFID_Flush, 1);
    check("rst_IDEX_Flush", IDEX_Flush, 1);
    check("rst_StallCycles", StallCycles, 0);
    next();
    reset = 0;
    // load from x0 never stalls
    IDEX_MemRead = 1; IDEX_RD = 0; IFID_RS1 = 0;
    @(negedge clk);
    check("x0_PCWrite", PCWrite, 1);
    check("x0_IDEX_Flush", IDEX_Flush, 0);
    next();
    idle();
    @(negedge clk);
    check("x0_State", State, 0);
    check("x0_StallCycles", StallCycles, 0);
    // one-cycle load-use stall, no retrigger while in LOAD_STALL
    next();
    IDEX_MemRead = 1; IDEX_RD = 5; IFID_RS1 = 5;
    @(negedge clk);
    check("lu_PCWrite", PCWrite, 0);
    check("lu_IFID_Write", IFID_Write, 0);
    check("lu_IDEX_Flush", IDEX_Flush, 1);
    check("lu_IDEX_Write", IDEX_Write, 1);
    next();
    @(negedge clk);
    check("lu_stall_State", State, 1);
    check("lu_stall_PCWrite", PCWrite, 1);
    next();
    idle();
    @(negedge clk);
    check("lu_after_State", State, 0);
    check("lu_StallCycles", StallCycles, 1);
    next();
    // branch wins over load-use; FLUSH ignores load-use
    do_reset();
    IDEX_MemRead = 1; IDEX_RD = 7; IFID_RS2 = 7; EX_BranchTaken = 1;
    @(negedge clk);
    check("br_PCWrite", PCWrite, 1);
    check("br_IFID_Flush", IFID_Flush, 1);
    check("br_IDEX_Flush", IDEX_Flush, 1);
    next();
    EX_BranchTaken = 0;
    @(negedge clk);
    check("br_State", State, 2);
    check("br_flush_PCWrite", PCWrite, 1);
    next();
    idle();
    @(negedge clk);
    check("br_after_State", State, 0);
    check("br_FlushEvents", FlushEvents, 1);
    check("br_StallCycles", StallCycles, 0);
    next();
    // memory wait freezes three cycles, then the held branch flushes
    do_reset();
    EXMEM_MemAccess = 1; DMem_Ready = 0; EX_BranchTaken = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_PCWrite", PCWrite, 0);
      check("mw_EXMEM_Write", EXMEM_Write, 0);
      check("mw_IFID_Flush", IFID_Flush, 0);
      check("mw_FlushEvents", FlushEvents, 0);
      next();
    end
    DMem_Ready = 1;
    @(negedge clk);
    check("mw_rdy_State", State, 3);
    check("mw_rdy_IFID_Flush", IFID_Flush, 1);
    check("mw_rdy_PCWrite", PCWrite, 1);
    next();
    idle();
    @(negedge clk);
    check("mw_after_State", State, 2);
    check("mw_FlushEvents", FlushEvents, 1);
    next();
    // reset during MEM_WAIT
    EXMEM_MemAccess = 1;
    next();
    @(negedge clk);
    check("rw_State_before", State, 3);
    idle();
    EXMEM_MemAccess = 1;
    reset = 1;
    @(negedge clk);
    check("rw_IFID_Flush", IFID_Flush, 1);
    check("rw_IDEX_Flush", IDEX_Flush, 1);
    next();
    reset = 0;
    idle();
    @(negedge clk);
    check("rw_State", State, 0);
    check("rw_FlushEvents", FlushEvents, 0);
    check("rw_StallCycles", StallCycles, 0);
    next();
    // saturation of the flush counter
    EX_BranchTaken = 1;
    repeat (65535) next();
    @(negedge clk);
    check("sat_preload", FlushEvents, 65535);
    next();
    @(negedge clk);
    check("sat_hold", FlushEvents, 65535);
    next();
    idle();
    next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- IFID_RS1, IFID_RS2  in  5 each  source registers of the instruction in ID.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_RD  in  5  destination register of the instruction in EX.
- EX_BranchTaken  in  1  branch or Jal resolved taken in EX this cycle.
- EXMEM_MemAccess  in  1  instruction in MEM reads or writes data memory.
- DMem_Ready  in  1  data memory completes the access this cycle.
- PCWrite, IFID_Write, IDEX_Write, EXMEM_Write  out  1 each  stage-register/PC enables; 1 = advance.
- IFID_Flush, IDEX_Flush  out  1 each  load a bubble (all controls 0) instead of the next value.
- State  out  2  current FSM state.
- StallCycles  out  16  saturating count of load-use stall cycles.
- FlushEvents  out  16  saturating count of taken-branch flushes.

Function
REQ-003 The block SHALL implement the FSM states RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-004 The block SHALL compute load_use = IDEX_MemRead & (IDEX_RD!=0) & (IDEX_RD==IFID_RS1 | IDEX_RD==IFID_RS2), combinationally.
REQ-005 The block SHALL compute mem_wait = EXMEM_MemAccess & ~DMem_Ready.
REQ-006 Event priority SHALL be mem_wait, then EX_BranchTaken, then load_use, evaluated in every state.
REQ-007 On mem_wait, the block SHALL drive all four Write enables 0 and both flushes 0; next state SHALL be MEM_WAIT; the counters SHALL be unchanged.
REQ-008 In MEM_WAIT with DMem_Ready=1, the block SHALL re-enable the pipeline and evaluate the lower-priority events in the same cycle; a branch held during the wait SHALL flush on that cycle.
REQ-009 On EX_BranchTaken without mem_wait, the block SHALL drive all Writes 1, IFID_Flush=1 and IDEX_Flush=1; next state SHALL be FLUSH; FlushEvents SHALL be incremented.
REQ-010 On load_use with no higher event, in RUN or FLUSH-exit, the block SHALL drive PCWrite=0, IFID_Write=0, IDEX_Flush=1, IDEX_Write=1 and EXMEM_Write=1; next state SHALL be LOAD_STALL; StallCycles SHALL be incremented.
REQ-011 In FLUSH, load_use SHALL be ignored for that one cycle because ID holds a bubble; the next state SHALL be RUN unless a new event occurs.
REQ-012 In LOAD_STALL, load_use SHALL NOT retrigger; the stall SHALL last exactly one cycle per load, and the next state SHALL be RUN.
REQ-013 With no event, the block SHALL drive all Writes 1 and both flushes 0; next state SHALL be RUN.
REQ-014 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-015 All outputs except State and the counters SHALL be combinational from the state and the current inputs, with zero latency.

Reset
REQ-016 While reset=1, the block SHALL set State=RUN and StallCycles=FlushEvents=0.
REQ-017 While reset=1, the block SHALL drive PCWrite=IFID_Write=IDEX_Write=EXMEM_Write=0 and IFID_Flush=IDEX_Flush=1.
REQ-018 A reset asserted mid-stall or mid-wait SHALL abandon the operation with no pending event retained; the first cycle after reset SHALL be RUN.

Structure
REQ-019 The state encoding, the counter width (16) and the saturation value SHALL reside in the shared package hazard_pkg.
REQ-020 The saturating counter SHALL be a sub-module sat_counter (inputs clk, reset, inc; output count), instantiated twice.

Verification
REQ-021 The bench SHALL drive IDEX_MemRead=1, IDEX_RD=5, IFID_RS1=5 and expect one cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1, then RUN, with StallCycles=1.
REQ-022 The bench SHALL drive load_use with IDEX_RD=0 and expect no stall and StallCycles=0.
REQ-023 The bench SHALL drive EX_BranchTaken=1 together with load_use and expect a flush only, State=FLUSH, then RUN next cycle, with FlushEvents=1 and StallCycles=0.
REQ-024 The bench SHALL drive EXMEM_MemAccess=1 with DMem_Ready=0 for 3 cycles while EX_BranchTaken=1 and expect 3 frozen cycles, then a flush on the Ready cycle, with FlushEvents=1.
REQ-025 The bench SHALL preload 65535 branch flushes and add one more, expecting FlushEvents to remain 16'hFFFF.
REQ-026 The bench SHALL assert reset during MEM_WAIT and expect State=0, counters 0 and flushes 1 on the next edge.
